// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor slice: FSM state
// encodings, the default operand width and the bit-counter width helper.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bit counter must index 0..WIDTH-1; a 1-bit operand still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fullsubtractor_bit.sv
// fullsubtractor_bit
// Combinational one-bit full subtractor: Diff = A - B - Bin.
// Ports:
//   A      in  minuend bit
//   B      in  subtrahend bit
//   Bin    in  borrow in
//   Diff   out difference bit
//   Borrow out borrow out
module fullsubtractor_bit (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Borrow
);

  always_comb begin
    Diff   = A ^ B ^ Bin;
    Borrow = (~A & B) | (~(A ^ B) & Bin);
  end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
// Bit-serial unsigned subtractor: computes Diff = (A - B) mod 2^WIDTH over
// WIDTH RUN cycles using one shared fullsubtractor_bit, LSB first, with the
// borrow held in a register between cycles.
// Ports:
//   clk    in  rising-edge clock
//   rst    in  asynchronous active-high reset
//   start  in  request; sampled only in IDLE
//   A, B   in  operands, captured on the accepting edge
//   busy   out high while in RUN
//   done   out one-cycle pulse, result valid
//   Diff   out result, holds until the next result
//   Borrow out final borrow (A < B), holds with Diff
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  localparam int unsigned   CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic [WIDTH-1:0] d_next;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             cell_d;
  logic             cell_bout;

  fullsubtractor_bit u_cell (
    .A      (a_sh[0]),
    .B      (b_sh[0]),
    .Bin    (br),
    .Diff   (cell_d),
    .Borrow (cell_bout)
  );

  // New difference bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
  // A 1-bit result has nothing to shift, so the cell output is the whole value.
  generate
    if (WIDTH == 1) begin : g_w1
      assign d_next = cell_d;
    end else begin : g_wn
      assign d_next = {cell_d, d_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      Diff   <= '0;
      Borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            br    <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= cell_bout;
          d_sh <= d_next;
          cnt  <= cnt + CW'(1);
          // Result registers take the shifted value including this final bit.
          if (cnt == LAST) begin
            Diff   <= d_next;
            Borrow <= cell_bout;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
